// File: rtl/uart_pg_loader_if.sv
// Program-download bus between the UART loader (master) and S86_sys (slave).
interface uart_pg_loader_if;
    logic        PG_CLK;
    logic        PG_RST;
    logic [1:0]  PG_WEN;
    logic [15:0] PG_DIN;
    logic [15:0] PG_ADR;
    logic        PG_DONE;
    logic        PG_ERR;

    modport master (output PG_CLK, PG_RST, PG_WEN, PG_DIN, PG_ADR, PG_DONE, PG_ERR);
    modport slave  (input  PG_CLK, PG_RST, PG_WEN, PG_DIN, PG_ADR, PG_DONE, PG_ERR);
endinterface

// File: rtl/uart_pg_loader.sv
// UART 8N1 receiver plus frame parser that streams a checksummed program image
// into S86 memory over the PG bus, holding the CPU in reset until the image verifies.
module uart_pg_loader #(
    parameter int          CLKS_PER_BIT = 87,
    parameter int          TIMEOUT_CYC  = 100000,
    parameter logic [7:0]  HDR_BYTE     = 8'hA5
) (
    input  logic             CLK10MHZ,
    input  logic             CPU_RESET,
    input  logic             UART_RXD,
    uart_pg_loader_if.master pg
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_t;
    typedef enum logic [2:0] {F_IDLE, F_CNT_LO, F_CNT_HI, F_DAT_LO, F_DAT_HI, F_CHK, F_DONE} f_st_t;

    // ---------------- UART receiver ----------------
    rx_st_t        rx_st, rx_st_n;
    logic          rx_s1, rx_s2, rx_prev;
    logic [CW-1:0] bcnt;
    logic [2:0]    bidx;
    logic [7:0]    shreg;
    logic          bit_tick, half_tick;
    logic          byte_valid, frame_err;
    logic [7:0]    rx_byte;

    assign bit_tick  = (bcnt == BIT_LAST);
    assign half_tick = (bcnt == HALF_LAST);
    assign rx_byte   = shreg;

    always_ff @(posedge CLK10MHZ) begin
        if (CPU_RESET) begin
            rx_st   <= R_IDLE;
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
            bcnt    <= '0;
            bidx    <= '0;
            shreg   <= '0;
        end else begin
            rx_st   <= rx_st_n;
            rx_s1   <= UART_RXD;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            bcnt    <= (rx_st == R_IDLE || rx_st != rx_st_n || bit_tick) ? '0 : bcnt + CW'(1);
            if (rx_st == R_START) begin
                bidx <= '0;
            end else if (rx_st == R_DATA && bit_tick) begin
                bidx  <= bidx + 3'd1;
                shreg <= {rx_s2, shreg[7:1]};
            end
        end
    end

    always_comb begin
        rx_st_n    = rx_st;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (rx_st)
            R_IDLE:  if (!rx_s2 && rx_prev) rx_st_n = R_START;
            // Re-check mid start bit so short line glitches are rejected
            R_START: if (half_tick) rx_st_n = rx_s2 ? R_IDLE : R_DATA;
            R_DATA:  if (bit_tick && bidx == 3'd7) rx_st_n = R_STOP;
            R_STOP: begin
                if (bit_tick) begin
                    byte_valid = rx_s2;
                    frame_err  = !rx_s2;
                    rx_st_n    = R_IDLE;
                end
            end
            default: rx_st_n = R_IDLE;
        endcase
    end

    // ---------------- frame parser ----------------
    f_st_t         f_st, f_st_n;
    logic [TW-1:0] tmr;
    logic [7:0]    cnt_lo, lo_byte, sum;
    logic [15:0]   left;
    logic          in_frame, hdr_acc, wr_now, go_done, abort;
    logic          rst_r, done_r, err_r;
    logic [1:0]    wen_r;
    logic [15:0]   din_r, adr_r;

    assign in_frame = (f_st != F_IDLE) && (f_st != F_DONE);

    always_comb begin
        f_st_n  = f_st;
        hdr_acc = 1'b0;
        wr_now  = 1'b0;
        go_done = 1'b0;
        abort   = 1'b0;
        case (f_st)
            F_IDLE, F_DONE: begin
                if (byte_valid && rx_byte == HDR_BYTE) begin
                    f_st_n  = F_CNT_LO;
                    hdr_acc = 1'b1;
                end
            end
            F_CNT_LO: if (byte_valid) f_st_n = F_CNT_HI;
            F_CNT_HI: if (byte_valid) f_st_n = ({rx_byte, cnt_lo} == 16'd0) ? F_CHK : F_DAT_LO;
            F_DAT_LO: if (byte_valid) f_st_n = F_DAT_HI;
            F_DAT_HI: begin
                if (byte_valid) begin
                    wr_now = 1'b1;
                    f_st_n = (left == 16'd1) ? F_CHK : F_DAT_LO;
                end
            end
            F_CHK: begin
                if (byte_valid) begin
                    if (rx_byte == sum) begin
                        go_done = 1'b1;
                        f_st_n  = F_DONE;
                    end else begin
                        abort  = 1'b1;
                        f_st_n = F_IDLE;
                    end
                end
            end
            default: f_st_n = F_IDLE;
        endcase
        // A byte landing on the timeout cycle still counts as activity
        if (in_frame && (frame_err || (!byte_valid && tmr == TO_LAST))) begin
            abort  = 1'b1;
            f_st_n = F_IDLE;
        end
    end

    always_ff @(posedge CLK10MHZ) begin
        if (CPU_RESET) begin
            f_st    <= F_IDLE;
            tmr     <= '0;
            cnt_lo  <= '0;
            lo_byte <= '0;
            sum     <= '0;
            left    <= '0;
            rst_r   <= 1'b1;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            wen_r   <= 2'b00;
            din_r   <= '0;
            adr_r   <= '0;
        end else begin
            f_st  <= f_st_n;
            tmr   <= (!in_frame || byte_valid) ? '0 : tmr + TW'(1);
            wen_r <= wr_now ? 2'b11 : 2'b00;
            if (wr_now) din_r <= {rx_byte, lo_byte};
            if (byte_valid) begin
                case (f_st)
                    F_CNT_LO: cnt_lo  <= rx_byte;
                    F_CNT_HI: left    <= {rx_byte, cnt_lo};
                    F_DAT_LO: lo_byte <= rx_byte;
                    F_DAT_HI: left    <= left - 16'd1;
                    default: ;
                endcase
            end
            if (byte_valid && in_frame && f_st != F_CHK) sum <= sum + rx_byte;
            if (hdr_acc) begin
                rst_r  <= 1'b1;
                done_r <= 1'b0;
                err_r  <= 1'b0;
                adr_r  <= '0;
                sum    <= '0;
            end else if (wen_r[0]) begin
                adr_r <= adr_r + 16'd1;
            end
            if (go_done) begin
                rst_r  <= 1'b0;
                done_r <= 1'b1;
            end
            if (abort) begin
                rst_r  <= 1'b1;
                done_r <= 1'b0;
                err_r  <= 1'b1;
            end
        end
    end

    assign pg.PG_CLK  = CLK10MHZ;
    assign pg.PG_RST  = rst_r;
    assign pg.PG_WEN  = wen_r;
    assign pg.PG_DIN  = din_r;
    assign pg.PG_ADR  = adr_r;
    assign pg.PG_DONE = done_r;
    assign pg.PG_ERR  = err_r;
endmodule
